trg_veto_release_ctl: RTL and testbench

- Sequences the trigger flow-control loop. Detects each new veto raised by the trigger block (TRG_NEEDS_VETO) and tracks readout-done pulses from every masked SCROD.
- Issues the one-cycle TRG_VETO_RESET pulse that starts the trigger block's veto-release countdown once all SCRODs are done, or when a timeout expires.
- Sits between the SCROD readout-done lines and the trigger block, in the CLK_42MHZ domain. Exports per-event diagnostics and counters.

---
 rtl/trg_veto_release_ctl.sv | 142 ++++++++++++++
 tb/tb_trg_veto_release_ctl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trg_veto_release_ctl.sv
// Trigger veto release sequencer: waits for masked SCROD DONEs after each veto edge, then pulses TRG_VETO_RESET.
// Latency: veto edge to release pulse is HOLDOFF_CYCLES+2 minimum, HOLDOFF_CYCLES+TIMEOUT_CYCLES+1 maximum.
// Backpressure: a held-high veto parks the FSM in WAIT_CLEAR; TRG_FLOW_CTL_EN low aborts to IDLE without a pulse.
module trg_veto_release_ctl #(
  parameter int HOLDOFF_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 4200000
) (
  input  logic        CLK_42MHZ,
  input  logic        RESET,
  input  logic        TRG_NEEDS_VETO,
  input  logic        TRG_FLOW_CTL_EN,
  input  logic [11:0] TRG_MASK,
  input  logic [11:0] DONE,
  input  logic        CNT_CLR,
  output logic        TRG_VETO_RESET,
  output logic [11:0] PENDING,
  output logic [11:0] TIMEOUT_MASK,
  output logic [31:0] EVENT_COUNT,
  output logic [15:0] TIMEOUT_COUNT,
  output logic        BUSY,
  output logic [2:0]  STATE
);

  // One timer serves both the holdoff and the collect window, so size it for the larger.
  localparam int TMAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HOLDOFF    = 3'd1,
    S_COLLECT    = 3'd2,
    S_RELEASE    = 3'd3,
    S_WAIT_CLEAR = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            veto_d;
  logic            veto_rise;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_nxt;
  logic [11:0]     pending_nxt;
  logic [11:0]     tmask_nxt;
  logic [11:0]     collect_next;
  logic            to_inc;
  logic            ev_inc;

  assign veto_rise = TRG_NEEDS_VETO & ~veto_d;
  assign STATE     = state;
  assign BUSY      = (state != S_IDLE);

  // Next-state, timer and pending-mask decode; flow-control disable overrides every state.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    pending_nxt  = PENDING;
    tmask_nxt    = TIMEOUT_MASK;
    to_inc       = 1'b0;
    ev_inc       = 1'b0;
    collect_next = PENDING & ~DONE;
    if (!TRG_FLOW_CTL_EN) begin
      state_nxt   = S_IDLE;
      pending_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (veto_rise) begin
            pending_nxt = TRG_MASK & ~DONE;
            timer_nxt   = TW'(HOLDOFF_CYCLES);
            state_nxt   = S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          pending_nxt = collect_next;
          if (timer == TW'(1)) begin
            timer_nxt = TW'(TIMEOUT_CYCLES);
            state_nxt = S_COLLECT;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        S_COLLECT: begin
          // A final DONE on the expiry cycle wins over the timeout.
          if (collect_next == '0) begin
            pending_nxt = '0;
            tmask_nxt   = '0;
            state_nxt   = S_RELEASE;
          end else if (timer == TW'(1)) begin
            tmask_nxt   = collect_next;
            to_inc      = 1'b1;
            state_nxt   = S_RELEASE;
          end else begin
            timer_nxt   = timer - 1'b1;
            pending_nxt = collect_next;
          end
        end
        S_RELEASE: begin
          ev_inc      = 1'b1;
          pending_nxt = '0;
          state_nxt   = S_WAIT_CLEAR;
        end
        S_WAIT_CLEAR: begin
          if (!TRG_NEEDS_VETO) state_nxt = S_IDLE;
        end
        default: begin
          state_nxt   = S_IDLE;
          pending_nxt = '0;
        end
      endcase
    end
  end

  // State, timer, diagnostics and counters; CNT_CLR beats a same-cycle increment.
  always_ff @(posedge CLK_42MHZ) begin
    if (RESET) begin
      state          <= S_IDLE;
      veto_d         <= 1'b0;
      timer          <= '0;
      PENDING        <= '0;
      TIMEOUT_MASK   <= '0;
      TRG_VETO_RESET <= 1'b0;
      EVENT_COUNT    <= '0;
      TIMEOUT_COUNT  <= '0;
    end else begin
      state          <= state_nxt;
      veto_d         <= TRG_NEEDS_VETO;
      timer          <= timer_nxt;
      PENDING        <= pending_nxt;
      TIMEOUT_MASK   <= tmask_nxt;
      TRG_VETO_RESET <= (state_nxt == S_RELEASE);
      if (CNT_CLR)
        EVENT_COUNT <= '0;
      else if (ev_inc)
        EVENT_COUNT <= EVENT_COUNT + 32'd1;
      if (CNT_CLR)
        TIMEOUT_COUNT <= '0;
      else if (to_inc && (TIMEOUT_COUNT != 16'hFFFF))
        TIMEOUT_COUNT <= TIMEOUT_COUNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_trg_veto_release_ctl.sv
// Bench for trg_veto_release_ctl: directed and randomized veto events against an event-level model.
// Model predicts release cycle, timeout mask and counters from per-SCROD DONE arrival times.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_trg_veto_release_ctl;

  localparam int HO = 8;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        veto;
  logic        en;
  logic [11:0] mask;
  logic [11:0] done;
  logic        cnt_clr;
  logic        vrst;
  logic [11:0] pending;
  logic [11:0] tmask;
  logic [31:0] ev_count;
  logic [15:0] to_count;
  logic        busy;
  logic [2:0]  state;

  always #5 clk = ~clk;

  trg_veto_release_ctl #(.HOLDOFF_CYCLES(HO), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_42MHZ      (clk),
    .RESET          (rst),
    .TRG_NEEDS_VETO (veto),
    .TRG_FLOW_CTL_EN(en),
    .TRG_MASK       (mask),
    .DONE           (done),
    .CNT_CLR        (cnt_clr),
    .TRG_VETO_RESET (vrst),
    .PENDING        (pending),
    .TIMEOUT_MASK   (tmask),
    .EVENT_COUNT    (ev_count),
    .TIMEOUT_COUNT  (to_count),
    .BUSY           (busy),
    .STATE          (state)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-SCROD first DONE cycle relative to the veto edge (-1 = never) and pulse width.
  int done_t[12];
  int done_w[12];

  // Model state: counters and last timeout mask.
  logic [31:0] m_ev;
  logic [15:0] m_to;
  logic [11:0] m_tmask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_times(input int a, input int b, input int c, input int d);
    for (int i = 0; i < 12; i++) begin
      done_t[i] = -1;
      done_w[i] = 1;
    end
    done_t[0] = a; done_t[1] = b; done_t[2] = c; done_t[3] = d;
  endtask

  // Cycle k = 0 is the first cycle the veto is high. A SCROD is cleared by its first
  // DONE cycle; the FSM releases one cycle after all are clear (never before HO+2), or at HO+TO+1.
  task automatic run_event(input logic [11:0] ev_mask, input int hold_extra, input bit clr);
    int          last;
    int          rel;
    int          pchk;
    logic [11:0] late;
    logic [11:0] exp_pend;
    logic [11:0] dv;
    late = '0;
    last = -1;
    for (int i = 0; i < 12; i++) begin
      if (ev_mask[i]) begin
        if (done_t[i] < 0 || done_t[i] > HO + TO) late[i] = 1'b1;
        else if (done_t[i] > last) last = done_t[i];
      end
    end
    if (late != '0) rel = HO + TO + 1;
    else rel = ((last > HO + 1) ? last : HO + 1) + 1;
    pchk = $urandom_range(1, rel - 1);

    for (int k = 0; k <= rel + 1 + hold_extra; k++) begin
      @(negedge clk);
      chk("release_pulse", 32'(vrst), 32'(k == rel));
      if (k == pchk) begin
        exp_pend = '0;
        for (int i = 0; i < 12; i++)
          if (ev_mask[i] && !(done_t[i] >= 0 && done_t[i] <= k - 1)) exp_pend[i] = 1'b1;
        chk("pending_mid_event", 32'(pending), 32'(exp_pend));
      end
      if (k == rel + 1) begin
        chk("state_wait_clear", 32'(state), 32'd4);
        chk("busy_wait_clear", 32'(busy), 32'd1);
      end
      veto = 1'b1;
      mask = (k == 0) ? ev_mask : 12'($urandom);
      dv   = ~ev_mask & 12'($urandom);
      for (int i = 0; i < 12; i++)
        if (ev_mask[i] && done_t[i] >= 0 && k >= done_t[i] && k < done_t[i] + done_w[i])
          dv[i] = 1'b1;
      done    = dv;
      cnt_clr = clr && (k == rel - 1 || k == rel);
    end

    if (clr) begin
      m_ev = '0;
      m_to = '0;
    end else begin
      m_ev = m_ev + 32'd1;
      if (late != '0 && m_to != 16'hFFFF) m_to = m_to + 16'd1;
    end
    m_tmask = late;

    @(negedge clk);
    chk("event_count", ev_count, m_ev);
    chk("timeout_count", 32'(to_count), 32'(m_to));
    chk("timeout_mask", 32'(tmask), 32'(m_tmask));
    chk("state_held", 32'(state), 32'd4);
    chk("pending_after", 32'(pending), 32'd0);
    veto    = 1'b0;
    done    = '0;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("state_idle_after", 32'(state), 32'd0);
    chk("busy_idle_after", 32'(busy), 32'd0);
  endtask

  // mode 0: drop flow-control enable mid-COLLECT; mode 1: assert RESET mid-HOLDOFF.
  task automatic abort_event(input int mode);
    int ab;
    ab = (mode == 0) ? 20 : 4;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      chk("abort_no_pulse", 32'(vrst), 32'd0);
      if (k == ab) begin
        chk("abort_pending_before", 32'(pending), 32'hFFF);
        chk("abort_state_before", 32'(state), (mode == 0) ? 32'd2 : 32'd1);
      end
      if (k == ab + 1) begin
        if (mode == 1) begin
          m_ev    = '0;
          m_to    = '0;
          m_tmask = '0;
        end
        chk("abort_pending", 32'(pending), 32'd0);
        chk("abort_ev_count", ev_count, m_ev);
        chk("abort_to_count", 32'(to_count), 32'(m_to));
        chk("abort_tmask", 32'(tmask), 32'(m_tmask));
      end
      if (k > ab) chk("abort_state_idle", 32'(state), 32'd0);
      veto = !(mode == 1 && k > ab);
      en   = !(mode == 0 && k == ab);
      rst  = (mode == 1 && k == ab);
      mask = (k == 0) ? 12'hFFF : 12'($urandom);
      done = '0;
    end
    @(negedge clk);
    veto = 1'b0;
    en   = 1'b1;
    rst  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; veto = 1'b0; en = 1'b1; mask = '0; done = '0; cnt_clr = 1'b0;
    m_ev = '0; m_to = '0; m_tmask = '0;
    repeat (3) @(negedge clk);
    chk("reset_pulse", 32'(vrst), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_tmask", 32'(tmask), 32'd0);
    chk("reset_ev_count", ev_count, 32'd0);
    chk("reset_to_count", 32'(to_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All four DONEs arrive: clean release at cycle 31.
    set_times(3, 10, 20, 30);
    run_event(12'h00F, 0, 1'b0);
    // DONE[2] missing: timeout release at cycle 109, mask 0x004.
    set_times(3, 10, -1, 30);
    run_event(12'h00F, 0, 1'b0);
    // Last DONE on the expiry cycle: clean release.
    set_times(108, 10, 20, 30);
    run_event(12'h00F, 0, 1'b0);
    // Empty mask, veto held long in WAIT_CLEAR, then a second empty-mask event.
    set_times(-1, -1, -1, -1);
    run_event(12'h000, 50, 1'b0);
    run_event(12'h000, 0, 1'b0);

    // Randomized events: masks, DONE arrival times and widths, unmasked DONE noise.
    for (int e = 0; e < 12; e++) begin
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 9) < 2) done_t[i] = -1;
        else done_t[i] = $urandom_range(0, (e % 2 == 0) ? 60 : 115);
        done_w[i] = $urandom_range(1, 3);
      end
      run_event(12'($urandom), $urandom_range(0, 5), 1'b0);
    end

    set_times(-1, -1, -1, -1);
    abort_event(0);
    abort_event(1);

    // Preload the timeout counter just below saturation.
    @(negedge clk);
    force dut.TIMEOUT_COUNT = 16'hFFFE;
    #1;
    release dut.TIMEOUT_COUNT;
    m_to = 16'hFFFE;
    @(negedge clk);
    chk("to_count_preload", 32'(to_count), 32'hFFFE);
    set_times(-1, 5, 6, 7);
    run_event(12'h00F, 0, 1'b0);
    run_event(12'h00F, 0, 1'b0);
    // Counter clear across the expiry and release cycles of a timeout event.
    run_event(12'h00F, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
